meteor_spawner: RTL and testbench
=================================

Name: meteor_spawner

Overview:
- Consumes the free-running random fields (new_pos, x_speed, y_speed, sign) and owns a fixed pool of meteor slots.
- On every frame tick it advances each active meteor and retires those that leave the screen.
- Every SPAWN_PERIOD frames it allocates a free slot using the current random fields.
- Sits between the random source and the draw/collision logic, which read and kill slots through a simple indexed interface.

Parameters:
- NUM_METEORS, 8, number of slots (power of two, at most 16)
- SPAWN_PERIOD, 60, frame ticks between spawn attempts (at least 1)
- SCREEN_W, 640, horizontal pixel limit
- SCREEN_H, 480, vertical pixel limit
- METEOR_SIZE, 16, sprite width, used to clamp spawn x

Ports:
- Clk  in  1  system clock; only clock
- Reset  in  1  synchronous, active-high reset
- frame_clk  in  1  vsync-derived level, synchronous to Clk; its rising edge is the frame tick
- new_pos  in  10  random spawn x seed
- x_speed  in  3  random horizontal speed magnitude
- y_speed  in  3  random vertical speed
- sign  in  1  horizontal direction; 1 = left
- kill_valid  in  1  collision logic requests slot clear
- kill_idx  in  $clog2(NUM_METEORS)  slot to clear
- rd_idx  in  $clog2(NUM_METEORS)  draw lookup index
- rd_active  out  1  slot rd_idx active; combinational from registers
- rd_x  out  10  slot rd_idx x
- rd_y  out  10  slot rd_idx y
- active_mask  out  NUM_METEORS  one bit per slot
- meteor_count  out  $clog2(NUM_METEORS)+1  popcount of active_mask
- spawn_pulse  out  1  single-cycle strobe when a slot is allocated

Behaviour:
- Reset:
  - all slots inactive with x = y = dx = dy = 0; state IDLE; spawn timer 0; spawn_pending 0; spawn_pulse 0.
  - frame_clk_d loads frame_clk, so no tick is generated at reset release even if frame_clk is high.
  - Reset asserted mid-pass aborts the pass immediately.
- Frame tick:
  - frame_tick = frame_clk & ~frame_clk_d; frame_clk_d is registered every cycle.
  - The spawn timer increments on every tick in any state. When the timer equals SPAWN_PERIOD-1 it wraps to 0 and sets spawn_pending.
- FSM states: IDLE, UPDATE, SPAWN.
  - IDLE: on frame_tick, go to UPDATE with idx = 0. Ticks arriving in UPDATE or SPAWN start no pass.
  - UPDATE: one slot per cycle.
    - If the slot is active, compute nx = signed 11-bit {0,x} + sext(dx) and ny = y + dy (11-bit).
    - If nx < 0, nx >= SCREEN_W, or ny >= SCREEN_H, clear active and hold x/y. Otherwise store nx/ny.
    - Inactive slots are untouched.
    - After idx = NUM_METEORS-1, go to SPAWN. The pass takes NUM_METEORS cycles.
  - SPAWN: one cycle, then IDLE.
    - If spawn_pending and a free slot exists, allocate the lowest-index free slot:
      - x = new_pos if new_pos <= SCREEN_W-METEOR_SIZE, else new_pos - 512
      - y = 0
      - dx = sign ? -x_speed : +x_speed (4-bit signed)
      - dy = (y_speed == 0) ? 1 : y_speed
      - active = 1; spawn_pulse = 1 for this cycle only.
    - spawn_pending always clears in SPAWN; a spawn with no free slot is dropped.
    - Random inputs are sampled only in this cycle.
    - A newly spawned meteor first moves on the next frame pass.
- Kill:
  - kill_valid clears active[kill_idx] in any state, including during a pass.
  - If UPDATE processes the same slot in the same cycle, kill wins and the slot stays inactive.
  - Free-slot search uses the registered mask, so a slot killed this cycle is not allocatable until the next cycle.
  - Kill of an already-inactive slot that SPAWN allocates in the same cycle: allocation wins.
- Outputs:
  - rd_*, active_mask and meteor_count are combinational from slot registers, zero latency.
  - Updated values are visible the cycle after the write.

Decomposition:
- meteor_pkg:
  - typedef enum state_t {IDLE, UPDATE, SPAWN}
  - struct meteor_t {active; x[9:0]; y[9:0]; dx signed[3:0]; dy[2:0]}
  - default screen constants
- Sub-module meteor_slot_alloc: combinational lowest-free-slot priority encoder. Input: active mask. Outputs: free_found, free_idx.

Test Plan:
1. Hold Reset 3 cycles with frame_clk = 1, then release with frame_clk held high for 10 cycles -> active_mask = 0, meteor_count = 0, no spawn_pulse, FSM stays IDLE.
2. SPAWN_PERIOD = 1, random inputs new_pos = 700, x_speed = 3, sign = 1, y_speed = 0, one frame edge -> after NUM_METEORS+1 cycles, spawn_pulse once; slot0 has x = 188, y = 0, dx = -3, dy = 1. Next frame -> x = 185, y = 1.
3. Slot at x = 2, dx = -3 -> after the next pass, slot inactive, meteor_count decremented. Separately, slot at y = 478, dy = 2 -> inactive.
4. All 8 slots active, spawn due -> no spawn_pulse, mask unchanged. Kill slot 5, then spawn due on the next frame -> slot 5 is allocated.
5. kill_valid with kill_idx = 3 in the same cycle UPDATE processes slot 3 (active, on-screen) -> slot 3 inactive afterward; slots 0-2 and 4-7 update normally.
6. Frame edges 1 cycle apart (second edge during UPDATE) -> only one pass runs, but the spawn timer advances twice: with SPAWN_PERIOD = 2, spawn_pending is set.

Source files
------------

// File: rtl/meteor_pkg.sv
// Shared types and screen defaults for the meteor spawner.
// The slot record keeps only what the movement and draw logic need.
package meteor_pkg;

   typedef enum logic [1:0] {IDLE, UPDATE, SPAWN} state_t;

   typedef struct packed {
      logic              active;
      logic [9:0]        x;
      logic [9:0]        y;
      logic signed [3:0] dx;
      logic [2:0]        dy;
   } meteor_t;

   localparam int DEF_SCREEN_W    = 640;
   localparam int DEF_SCREEN_H    = 480;
   localparam int DEF_METEOR_SIZE = 16;

   // A seed past the right edge folds back by 512 so the sprite stays on screen.
   function automatic logic [9:0] clamp_spawn_x(input logic [9:0] pos, input int limit);
      return (int'(pos) <= limit) ? pos : pos - 10'd512;
   endfunction

endpackage

// File: rtl/meteor_slot_alloc.sv
// Lowest-index free slot finder over the registered active mask.
module meteor_slot_alloc
   import meteor_pkg::*;
#(
   parameter int NUM_METEORS = 8
) (
   input  logic [NUM_METEORS-1:0]         mask,
   output logic                           free_found,
   output logic [$clog2(NUM_METEORS)-1:0] free_idx
);
   localparam int IW = $clog2(NUM_METEORS);

   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      // Descending scan so the lowest free index is the last one written.
      for (int i = NUM_METEORS - 1; i >= 0; i--) begin
         if (!mask[i]) begin
            free_found = 1'b1;
            free_idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/meteor_spawner.sv
// Meteor slot pool: per-frame movement pass, periodic spawning and indexed
// kill/read access for the draw and collision logic.
module meteor_spawner
   import meteor_pkg::*;
#(
   parameter int NUM_METEORS  = 8,
   parameter int SPAWN_PERIOD = 60,
   parameter int SCREEN_W     = DEF_SCREEN_W,
   parameter int SCREEN_H     = DEF_SCREEN_H,
   parameter int METEOR_SIZE  = DEF_METEOR_SIZE
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           frame_clk,
   input  logic [9:0]                     new_pos,
   input  logic [2:0]                     x_speed,
   input  logic [2:0]                     y_speed,
   input  logic                           sign,
   input  logic                           kill_valid,
   input  logic [$clog2(NUM_METEORS)-1:0] kill_idx,
   input  logic [$clog2(NUM_METEORS)-1:0] rd_idx,
   output logic                           rd_active,
   output logic [9:0]                     rd_x,
   output logic [9:0]                     rd_y,
   output logic [NUM_METEORS-1:0]         active_mask,
   output logic [$clog2(NUM_METEORS):0]   meteor_count,
   output logic                           spawn_pulse
);
   localparam int IW = $clog2(NUM_METEORS);
   localparam int CW = IW + 1;
   localparam int TW = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;

   meteor_t          slots [NUM_METEORS];
   state_t           state;
   logic [IW-1:0]    idx;
   logic [TW-1:0]    timer;
   logic             spawn_pending;
   logic             frame_clk_d;
   logic             frame_tick;
   logic             free_found;
   logic [IW-1:0]    free_idx;
   logic [NUM_METEORS-1:0] mask;
   logic [CW-1:0]    count;
   meteor_t          cur;
   logic signed [10:0] nx;
   logic [10:0]      ny;
   logic             off_screen;
   logic             do_spawn;
   meteor_t          spawn_slot;

   always_comb begin
      mask  = '0;
      count = '0;
      for (int i = 0; i < NUM_METEORS; i++) begin
         mask[i] = slots[i].active;
         count   = count + CW'(slots[i].active);
      end
   end

   meteor_slot_alloc #(.NUM_METEORS(NUM_METEORS)) u_alloc (
      .mask       (mask),
      .free_found (free_found),
      .free_idx   (free_idx)
   );

   assign frame_tick = frame_clk & ~frame_clk_d;
   assign cur        = slots[idx];
   assign nx         = $signed({1'b0, cur.x}) + $signed({{7{cur.dx[3]}}, cur.dx});
   assign ny         = {1'b0, cur.y} + {8'b0, cur.dy};
   // Bit 10 of nx covers both negative results and the unreachable >1023 case.
   assign off_screen = nx[10] || (nx[9:0] >= 10'(SCREEN_W)) || (ny >= 11'(SCREEN_H));
   assign do_spawn   = (state == SPAWN) && spawn_pending && free_found;

   always_comb begin
      spawn_slot        = '0;
      spawn_slot.active = 1'b1;
      spawn_slot.x      = clamp_spawn_x(new_pos, SCREEN_W - METEOR_SIZE);
      spawn_slot.y      = '0;
      spawn_slot.dx     = sign ? -$signed({1'b0, x_speed}) : $signed({1'b0, x_speed});
      spawn_slot.dy     = (y_speed == 3'd0) ? 3'd1 : y_speed;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_METEORS; i++) slots[i] <= '0;
         state         <= IDLE;
         idx           <= '0;
         timer         <= '0;
         spawn_pending <= 1'b0;
         spawn_pulse   <= 1'b0;
         frame_clk_d   <= frame_clk;
      end else begin
         frame_clk_d <= frame_clk;
         spawn_pulse <= do_spawn;
         if (frame_tick) begin
            if (timer == TW'(SPAWN_PERIOD - 1)) begin
               timer         <= '0;
               spawn_pending <= 1'b1;
            end else begin
               timer <= timer + 1'b1;
            end
         end
         case (state)
            IDLE: begin
               if (frame_tick) begin
                  state <= UPDATE;
                  idx   <= '0;
               end
            end
            UPDATE: begin
               if (cur.active) begin
                  if (off_screen) begin
                     slots[idx].active <= 1'b0;
                  end else begin
                     slots[idx].x <= nx[9:0];
                     slots[idx].y <= ny[9:0];
                  end
               end
               if (idx == IW'(NUM_METEORS - 1)) state <= SPAWN;
               else                             idx   <= idx + 1'b1;
            end
            SPAWN: begin
               spawn_pending <= 1'b0;
               state         <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // Kill overrides the pass write; an allocation overrides the kill.
         if (kill_valid) slots[kill_idx].active <= 1'b0;
         if (do_spawn)   slots[free_idx] <= spawn_slot;
      end
   end

   assign rd_active    = slots[rd_idx].active;
   assign rd_x         = slots[rd_idx].x;
   assign rd_y         = slots[rd_idx].y;
   assign active_mask  = mask;
   assign meteor_count = count;

endmodule

// File: tb/tb_meteor_spawner.sv
// Randomized bench for meteor_spawner with a frame-level reference model and a spawn scoreboard.
module tb_meteor_spawner;
   localparam int N  = 8;
   localparam int P  = 2;
   localparam int SW = 640;
   localparam int SH = 480;
   localparam int MS = 16;
   localparam int IW = $clog2(N);

   logic          Clk = 1'b0;
   logic          Reset = 1'b1;
   logic          frame_clk = 1'b1;
   logic [9:0]    new_pos = '0;
   logic [2:0]    x_speed = '0;
   logic [2:0]    y_speed = '0;
   logic          sign = 1'b0;
   logic          kill_valid = 1'b0;
   logic [IW-1:0] kill_idx = '0;
   logic [IW-1:0] rd_idx = '0;
   logic          rd_active;
   logic [9:0]    rd_x;
   logic [9:0]    rd_y;
   logic [N-1:0]  active_mask;
   logic [IW:0]   meteor_count;
   logic          spawn_pulse;

   meteor_spawner #(
      .NUM_METEORS(N), .SPAWN_PERIOD(P), .SCREEN_W(SW), .SCREEN_H(SH), .METEOR_SIZE(MS)
   ) dut (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .new_pos(new_pos),
      .x_speed(x_speed), .y_speed(y_speed), .sign(sign), .kill_valid(kill_valid),
      .kill_idx(kill_idx), .rd_idx(rd_idx), .rd_active(rd_active), .rd_x(rd_x),
      .rd_y(rd_y), .active_mask(active_mask), .meteor_count(meteor_count),
      .spawn_pulse(spawn_pulse)
   );

   always #5 Clk = ~Clk;

   int tests = 0;
   int fails = 0;
   int pulses = 0;
   int spawns_expected = 0;

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: slot contents as plain integers, one call per frame.
   int m_act [N];
   int m_x   [N];
   int m_y   [N];
   int m_dx  [N];
   int m_dy  [N];
   int m_known [N];
   int m_ticks;
   bit m_pend;
   int exp_mask_q [$];

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dx[i] = 0; m_dy[i] = 0; m_known[i] = 1;
      end
      m_ticks = 0;
      m_pend  = 0;
   endtask

   function automatic int model_mask();
      int m = 0;
      for (int i = 0; i < N; i++) if (m_act[i] != 0) m |= (1 << i);
      return m;
   endfunction

   function automatic int model_count();
      int c = 0;
      for (int i = 0; i < N; i++) c += (m_act[i] != 0) ? 1 : 0;
      return c;
   endfunction

   function automatic int model_lowest_free();
      for (int i = 0; i < N; i++) if (m_act[i] == 0) return i;
      return -1;
   endfunction

   task automatic model_tick();
      m_ticks++;
      if (m_ticks % P == 0) m_pend = 1;
   endtask

   // kill_c: cycle of the kill relative to the frame edge (0 = edge cycle,
   // 1..N = while slot kill_c-1 is being moved, N+1 = spawn cycle, -1 = none).
   task automatic model_frame(int kill_c, int kslot, bit dbl, int npos, int xs, int ys, bit sg);
      int alloc = -1;
      model_tick();
      if (dbl) model_tick();
      if (kill_c == 0) m_act[kslot] = 0;
      for (int i = 0; i < N; i++) begin
         if (kill_c == i + 1) begin
            if (kslot == i && m_act[i] != 0) m_known[i] = 0;
            m_act[kslot] = 0;
         end
         if (m_act[i] != 0) begin
            int nx = m_x[i] + m_dx[i];
            int ny = m_y[i] + m_dy[i];
            if (nx < 0 || nx >= SW || ny >= SH) m_act[i] = 0;
            else begin m_x[i] = nx; m_y[i] = ny; end
         end
      end
      if (m_pend) begin
         alloc = model_lowest_free();
         if (alloc >= 0) begin
            m_act[alloc]   = 1;
            m_x[alloc]     = (npos <= SW - MS) ? npos : npos - 512;
            m_y[alloc]     = 0;
            m_dx[alloc]    = sg ? -xs : xs;
            m_dy[alloc]    = (ys == 0) ? 1 : ys;
            m_known[alloc] = 1;
         end
      end
      m_pend = 0;
      if (kill_c == N + 1 && kslot != alloc) m_act[kslot] = 0;
      if (alloc >= 0) begin
         exp_mask_q.push_back(model_mask());
         spawns_expected++;
      end
   endtask

   // Monitor: every spawn strobe is matched against the next expected mask.
   always @(negedge Clk) begin
      if (!Reset && spawn_pulse === 1'b1) begin
         pulses++;
         chk("spawn_expected", int'(exp_mask_q.size() > 0), 1);
         if (exp_mask_q.size() > 0) begin
            int e;
            e = exp_mask_q.pop_front();
            chk("spawn_mask", int'(active_mask), e);
            chk("spawn_count", int'(meteor_count), $countones(e));
         end
      end
   end

   task automatic snapshot(string tag);
      chk({tag, "_mask"}, int'(active_mask), model_mask());
      chk({tag, "_count"}, int'(meteor_count), model_count());
      chk({tag, "_spawn_drained"}, exp_mask_q.size(), 0);
      for (int i = 0; i < N; i++) begin
         rd_idx = IW'(i);
         #1;
         chk($sformatf("%s_act%0d", tag, i), int'(rd_active), m_act[i]);
         if (m_known[i] != 0) begin
            chk($sformatf("%s_x%0d", tag, i), int'(rd_x), m_x[i]);
            chk($sformatf("%s_y%0d", tag, i), int'(rd_y), m_y[i]);
         end
      end
      @(negedge Clk);
   endtask

   task automatic do_frame(string tag, int kill_c, int kslot, bit dbl);
      model_frame(kill_c, kslot, dbl, int'(new_pos), int'(x_speed), int'(y_speed), sign);
      for (int c = 0; c <= N + 4; c++) begin
         frame_clk  = dbl ? (c == 0 || c == 2) : (c <= 1);
         kill_valid = (c == kill_c);
         kill_idx   = IW'(kslot);
         @(negedge Clk);
      end
      frame_clk  = 1'b0;
      kill_valid = 1'b0;
      snapshot(tag);
   endtask

   task automatic idle_kill(int k);
      kill_valid = 1'b1;
      kill_idx   = IW'(k);
      @(negedge Clk);
      kill_valid = 1'b0;
      m_act[k]   = 0;
   endtask

   task automatic randomize_inputs();
      new_pos = 10'($urandom_range(0, 1023));
      x_speed = 3'($urandom_range(0, 7));
      y_speed = 3'($urandom_range(0, 7));
      sign    = 1'($urandom_range(0, 1));
   endtask

   task automatic random_frame(string tag);
      int kc = -1;
      int ks;
      bit dbl;
      randomize_inputs();
      if ($urandom_range(0, 5) == 0) idle_kill(int'($urandom_range(0, N - 1)));
      ks = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 4) == 0) begin
         kc = int'($urandom_range(0, N + 1));
         if (kc == N + 1 && model_lowest_free() >= 0 && $urandom_range(0, 1) == 1)
            ks = model_lowest_free();
      end
      dbl = ($urandom_range(0, 7) == 0);
      do_frame(tag, kc, ks, dbl);
   endtask

   initial begin
      model_reset();
      Reset     = 1'b1;
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         chk("reset_mask", int'(active_mask), 0);
         chk("reset_count", int'(meteor_count), 0);
      end
      chk("reset_no_pulse", pulses, 0);
      frame_clk = 1'b0;
      @(negedge Clk);

      new_pos = 10'd700; x_speed = 3'd3; sign = 1'b1; y_speed = 3'd0;
      do_frame("first", -1, 0, 1'b0);
      do_frame("spawn0", -1, 0, 1'b0);
      do_frame("move0", -1, 0, 1'b0);
      rd_idx = '0;
      #1;
      chk("slot0_x_after_move", int'(rd_x), 185);
      chk("slot0_y_after_move", int'(rd_y), 1);
      @(negedge Clk);

      for (int f = 0; f < 12; f++) random_frame("fill");
      do_frame("kill_same_slot", 4, 3, 1'b0);
      randomize_inputs();
      do_frame("double_edge", -1, 0, 1'b1);
      for (int f = 0; f < 110; f++) random_frame("rand");

      frame_clk = 1'b1;
      repeat (2) @(negedge Clk);
      frame_clk = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      model_reset();
      exp_mask_q.delete();
      @(negedge Clk);
      snapshot("abort");
      for (int f = 0; f < 10; f++) random_frame("post");

      chk("pulse_total", pulses, spawns_expected);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
